// File: rtl/dplca_txop_table_ctrl_pkg.sv
// D-PLCA TXOP claim table: shared constants, entry and FSM encodings.
// Provides table geometry, entry_e/state_e types and the aging helper.
package dplca_txop_table_ctrl_pkg;

  localparam int NUM_ENTRIES = 256;
  localparam int ENTRY_W     = 2;
  localparam int TABLE_W     = NUM_ENTRIES * ENTRY_W;
  localparam int ID_W        = 8;

  typedef enum logic [1:0] {
    UNCLAIMED = 2'b00,
    SOFT      = 2'b01,
    HARD      = 2'b10
  } entry_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // One aging step; the reserved code decays straight to UNCLAIMED.
  function automatic logic [ENTRY_W-1:0] age_entry(
    input logic [ENTRY_W-1:0] e
  );
    logic [ENTRY_W-1:0] r;
    case (e)
      HARD:    r = SOFT;
      SOFT:    r = UNCLAIMED;
      default: r = UNCLAIMED;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dplca_max_claim_tracker.sv
// Tracks the highest TXOP ID in HARD state: running max on claims,
// rebuilt from mid-scan claims when an age scan completes.
// Ports: clk, clr (sync reset), flush (aging off), claim_we/claim_id,
//        scan_start/scan_active/scan_idx/scan_done, max_hard (out).
module dplca_max_claim_tracker
  import dplca_txop_table_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            flush,
  input  logic            claim_we,
  input  logic [ID_W-1:0] claim_id,
  input  logic            scan_start,
  input  logic            scan_active,
  input  logic [ID_W-1:0] scan_idx,
  input  logic            scan_done,
  output logic [ID_W-1:0] max_hard
);

  logic [ID_W-1:0] max_q, max_d;
  logic [ID_W-1:0] scan_max_q, scan_max_d;
  logic            scan_hit;

  always_comb begin
    // A claim at or below the scan pointer is never aged again this
    // scan, so it is HARD once the scan ends.
    scan_hit   = scan_active && claim_we && (claim_id <= scan_idx);
    max_d      = max_q;
    scan_max_d = scan_max_q;
    if (scan_start) begin
      scan_max_d = '0;
    end
    if (scan_hit && (claim_id > scan_max_q)) begin
      scan_max_d = claim_id;
    end
    if (claim_we && (claim_id > max_q)) begin
      max_d = claim_id;
    end
    if (scan_done) begin
      max_d = scan_max_d;
    end
    if (flush) begin
      scan_max_d = '0;
      max_d      = claim_we ? claim_id : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      max_q      <= '0;
      scan_max_q <= '0;
    end else begin
      max_q      <= max_d;
      scan_max_q <= scan_max_d;
    end
  end

  assign max_hard = max_q;

endmodule

// File: rtl/dplca_txop_table_ctrl.sv
// D-PLCA TXOP claim table with age scanning and beacon-synced updates.
// In: clk, plca_reset, dplca_aging, age_tick, claim_valid, claim_id,
//     beacon_seen. Out: table, upd, new_age, max_hard_claim, overrun.
module dplca_txop_table_ctrl
  import dplca_txop_table_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               plca_reset,
  input  logic               dplca_aging,
  input  logic               age_tick,
  input  logic               claim_valid,
  input  logic [ID_W-1:0]    claim_id,
  input  logic               beacon_seen,
  output logic [TABLE_W-1:0] txop_claim_table_unpacked,
  output logic               dplca_txop_table_upd,
  output logic               dplca_new_age,
  output logic [ID_W-1:0]    max_hard_claim,
  output logic               age_overrun
);

  state_e state_q, state_d;

  logic [ID_W-1:0] idx_q, idx_d;
  logic [NUM_ENTRIES-1:0][ENTRY_W-1:0] tbl_q, tbl_d;
  logic pend_q, pend_d;
  logic new_age_q, new_age_d;
  logic upd_q, upd_d;
  logic ovr_q, ovr_d;

  logic in_idle;
  logic in_scan;
  logic scan_go;
  logic hit_idx;
  logic scan_step;
  logic scan_done;
  logic tick_busy;

  // Control decode shared by the FSM and datapath.
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    in_scan   = (state_q == ST_SCAN);
    scan_go   = in_idle && age_tick && dplca_aging;
    hit_idx   = claim_valid && (claim_id == idx_q);
    // A claim on the scanned entry replaces its aging step; any other
    // claim owns the write port and stalls the scan.
    scan_step = in_scan && dplca_aging &&
                (!claim_valid || hit_idx);
    scan_done = scan_step && (idx_q == ID_W'(NUM_ENTRIES - 1));
    tick_busy = in_scan && age_tick && dplca_aging;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (scan_go)   state_d = ST_SCAN;
      ST_SCAN: if (scan_done) state_d = ST_IDLE;
    endcase
    if (!dplca_aging) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (plca_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    idx_d     = idx_q;
    tbl_d     = tbl_q;
    pend_d    = pend_q;
    new_age_d = new_age_q;
    upd_d     = 1'b0;
    ovr_d     = ovr_q | tick_busy;

    if (scan_go) begin
      idx_d = '0;
    end
    if (scan_step) begin
      idx_d        = idx_q + ID_W'(1);
      tbl_d[idx_q] = age_entry(tbl_q[idx_q]);
    end
    if (claim_valid) begin
      tbl_d[claim_id] = HARD;
    end

    if (beacon_seen && in_idle) begin
      upd_d = 1'b1;
    end
    if (beacon_seen && in_scan) begin
      pend_d = 1'b1;
    end

    // new_age stays up until the update pulse that reports it.
    if (upd_q) begin
      new_age_d = 1'b0;
    end
    if (scan_done) begin
      new_age_d = 1'b1;
      upd_d     = pend_d;
      pend_d    = 1'b0;
    end

    if (!dplca_aging) begin
      tbl_d = '0;
      if (claim_valid) begin
        tbl_d[claim_id] = HARD;
      end
      idx_d     = '0;
      pend_d    = 1'b0;
      new_age_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (plca_reset) begin
      idx_q     <= '0;
      tbl_q     <= '0;
      pend_q    <= 1'b0;
      new_age_q <= 1'b0;
      upd_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      tbl_q     <= tbl_d;
      pend_q    <= pend_d;
      new_age_q <= new_age_d;
      upd_q     <= upd_d;
      ovr_q     <= ovr_d;
    end
  end

  dplca_max_claim_tracker u_max (
    .clk         (clk),
    .clr         (plca_reset),
    .flush       (!dplca_aging),
    .claim_we    (claim_valid),
    .claim_id    (claim_id),
    .scan_start  (scan_go),
    .scan_active (in_scan && dplca_aging),
    .scan_idx    (idx_q),
    .scan_done   (scan_done),
    .max_hard    (max_hard_claim)
  );

  assign txop_claim_table_unpacked = tbl_q;
  assign dplca_txop_table_upd      = upd_q;
  assign dplca_new_age             = new_age_q;
  assign age_overrun               = ovr_q;

endmodule

// File: tb/tb_dplca_txop_table_ctrl.sv
// Directed bench for dplca_txop_table_ctrl: claims, aging scans,
// stalls, deferred beacon updates, max tracking and aborts.
module tb_dplca_txop_table_ctrl;

  logic         clk = 1'b0;
  logic         plca_reset;
  logic         dplca_aging;
  logic         age_tick;
  logic         claim_valid;
  logic [7:0]   claim_id;
  logic         beacon_seen;
  logic [511:0] tbl;
  logic         upd;
  logic         new_age;
  logic [7:0]   max_hc;
  logic         ovr;

  int nvec = 0;
  int nerr = 0;

  dplca_txop_table_ctrl dut (
    .clk                       (clk),
    .plca_reset                (plca_reset),
    .dplca_aging               (dplca_aging),
    .age_tick                  (age_tick),
    .claim_valid               (claim_valid),
    .claim_id                  (claim_id),
    .beacon_seen               (beacon_seen),
    .txop_claim_table_unpacked (tbl),
    .dplca_txop_table_upd      (upd),
    .dplca_new_age             (new_age),
    .max_hard_claim            (max_hc),
    .age_overrun               (ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ent(input int i);
    return tbl[2*i +: 2];
  endfunction

  task automatic wait_age(inout int cnt, output int early);
    early = 0;
    while (!new_age && cnt < 600) begin
      cyc(1);
      cnt++;
      if (upd && !new_age) early++;
    end
  endtask

  task automatic start_scan();
    age_tick = 1'b1;
    cyc(1);
    age_tick = 1'b0;
  endtask

  task automatic claim(input logic [7:0] id);
    claim_valid = 1'b1;
    claim_id    = id;
    cyc(1);
    claim_valid = 1'b0;
  endtask

  // Beacon in IDLE: upd next cycle, new_age clears the cycle after.
  task automatic flush();
    beacon_seen = 1'b1;
    cyc(1);
    beacon_seen = 1'b0;
    cyc(1);
  endtask

  task automatic quiet(input int n, output int ev);
    ev = 0;
    repeat (n) begin
      cyc(1);
      if (upd || new_age) ev++;
    end
  endtask

  initial begin
    int cnt;
    int early;
    int ev;

    plca_reset  = 1'b1;
    dplca_aging = 1'b1;
    age_tick    = 1'b0;
    claim_valid = 1'b0;
    claim_id    = 8'd0;
    beacon_seen = 1'b0;
    cyc(2);
    chk("rst_tbl", 32'(tbl == '0), 32'd1);
    chk("rst_upd", 32'(upd), 32'd0);
    chk("rst_age", 32'(new_age), 32'd0);
    chk("rst_max", 32'(max_hc), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    plca_reset = 1'b0;
    cyc(1);

    // Claim then age twice.
    claim(8'd5);
    chk("c5_hard", 32'(ent(5)), 32'd2);
    chk("c5_max", 32'(max_hc), 32'd5);
    start_scan();
    cnt = 0;
    wait_age(cnt, early);
    chk("a1_len", 32'(cnt), 32'd256);
    chk("a1_e5", 32'(ent(5)), 32'd1);
    chk("a1_max", 32'(max_hc), 32'd0);
    chk("a1_upd", 32'(upd), 32'd0);
    flush();
    chk("a1_clr", 32'(new_age), 32'd0);
    start_scan();
    cnt = 0;
    wait_age(cnt, early);
    chk("a2_len", 32'(cnt), 32'd256);
    chk("a2_e5", 32'(ent(5)), 32'd0);

    // Beacon in IDLE while new_age is set.
    beacon_seen = 1'b1;
    cyc(1);
    beacon_seen = 1'b0;
    chk("bi_upd", 32'(upd), 32'd1);
    chk("bi_age", 32'(new_age), 32'd1);
    cyc(1);
    chk("bi_upd0", 32'(upd), 32'd0);
    chk("bi_age0", 32'(new_age), 32'd0);

    // Ten stalled cycles on already-scanned entries.
    start_scan();
    cnt = 0;
    cyc(50);
    cnt = 50;
    for (int k = 0; k < 10; k++) begin
      claim_valid = 1'b1;
      claim_id    = 8'(20 + k);
      cyc(1);
      cnt++;
    end
    claim_valid = 1'b0;
    wait_age(cnt, early);
    chk("st_len", 32'(cnt), 32'd266);
    chk("st_e20", 32'(ent(20)), 32'd2);
    chk("st_e29", 32'(ent(29)), 32'd2);
    chk("st_max", 32'(max_hc), 32'd29);
    chk("st_upd", 32'(upd), 32'd0);
    flush();

    // Deferred update, two beacons collapse.
    start_scan();
    cnt = 0;
    cyc(99);
    cnt = 99;
    beacon_seen = 1'b1;
    cyc(1);
    cnt++;
    beacon_seen = 1'b0;
    chk("df_upd_a", 32'(upd), 32'd0);
    cyc(49);
    cnt += 49;
    beacon_seen = 1'b1;
    cyc(1);
    cnt++;
    beacon_seen = 1'b0;
    chk("df_upd_b", 32'(upd), 32'd0);
    wait_age(cnt, early);
    chk("df_len", 32'(cnt), 32'd256);
    chk("df_early", 32'(early), 32'd0);
    chk("df_upd", 32'(upd), 32'd1);
    chk("df_age", 32'(new_age), 32'd1);
    cyc(1);
    chk("df_upd0", 32'(upd), 32'd0);
    chk("df_age0", 32'(new_age), 32'd0);
    cyc(1);
    chk("df_once", 32'(upd), 32'd0);

    // Max tracking.
    claim(8'd3);
    claim(8'd200);
    claim(8'd7);
    chk("mx_200", 32'(max_hc), 32'd200);
    chk("mx_e200", 32'(ent(200)), 32'd2);
    start_scan();
    cnt = 0;
    cyc(20);
    cnt = 20;
    claim(8'd7);
    cnt++;
    wait_age(cnt, early);
    chk("mx1_len", 32'(cnt), 32'd257);
    chk("mx1_max", 32'(max_hc), 32'd7);
    chk("mx1_e200", 32'(ent(200)), 32'd1);
    chk("mx1_e7", 32'(ent(7)), 32'd2);
    chk("mx1_e3", 32'(ent(3)), 32'd1);
    flush();
    start_scan();
    cyc(20);
    claim(8'd7);
    cnt = 21;
    wait_age(cnt, early);
    chk("mx2_max", 32'(max_hc), 32'd7);
    chk("mx2_e200", 32'(ent(200)), 32'd0);
    chk("mx2_e3", 32'(ent(3)), 32'd0);
    chk("mx2_e7", 32'(ent(7)), 32'd2);
    flush();

    // Claim on the entry under the scan pointer.
    start_scan();
    cyc(30);
    claim(8'd30);
    cnt = 31;
    wait_age(cnt, early);
    chk("hi_e30", 32'(ent(30)), 32'd2);
    chk("hi_max", 32'(max_hc), 32'd30);
    flush();

    // Reset mid-scan.
    claim(8'd9);
    start_scan();
    cyc(49);
    plca_reset = 1'b1;
    cyc(1);
    plca_reset = 1'b0;
    chk("rs_tbl", 32'(tbl == '0), 32'd1);
    chk("rs_age", 32'(new_age), 32'd0);
    chk("rs_upd", 32'(upd), 32'd0);
    chk("rs_max", 32'(max_hc), 32'd0);
    quiet(300, ev);
    chk("rs_quiet", 32'(ev), 32'd0);
    start_scan();
    cnt = 0;
    wait_age(cnt, early);
    chk("rs_len", 32'(cnt), 32'd256);
    flush();

    // Overrun, then aging disabled mid-scan.
    claim(8'd9);
    chk("ao_ovr0", 32'(ovr), 32'd0);
    start_scan();
    cyc(10);
    age_tick = 1'b1;
    cyc(1);
    age_tick = 1'b0;
    chk("ao_ovr", 32'(ovr), 32'd1);
    cyc(38);
    dplca_aging = 1'b0;
    cyc(1);
    dplca_aging = 1'b1;
    chk("ao_tbl", 32'(tbl == '0), 32'd1);
    chk("ao_age", 32'(new_age), 32'd0);
    chk("ao_upd", 32'(upd), 32'd0);
    chk("ao_max", 32'(max_hc), 32'd0);
    quiet(300, ev);
    chk("ao_quiet", 32'(ev), 32'd0);
    chk("ao_stick", 32'(ovr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dplca_txop_table_ctrl.md
DPLCA_TXOP_TABLE_CTRL -- requirements
Module: dplca_txop_table_ctrl

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- plca_reset  in  1  synchronous, active-high reset.
- dplca_aging  in  1  aging enable (ON=1); low clears the table.
- age_tick  in  1  one-cycle pulse from the aging timer; starts an age scan.
- claim_valid  in  1  one-cycle pulse; a TXOP claim was observed on the medium.
- claim_id  in  8  TXOP ID claimed; sampled when claim_valid=1.
- beacon_seen  in  1  one-cycle pulse; a BEACON was received, so the TXOP cycle ended.
- txop_claim_table_unpacked  out  512  entry i at bits [2i+1:2i].
- dplca_txop_table_upd  out  1  one-cycle pulse; table snapshot is valid for the cycle.
- dplca_new_age  out  1  level; an age scan has completed since the last table update.
- max_hard_claim  out  8  highest ID in HARD state; 0 if none.
- age_overrun  out  1  sticky; an age_tick arrived while a scan was busy.

REQ-002 SHALL use one clock and one reset; reset SHALL be synchronous and active-high on plca_reset.

REQ-003 SHALL encode entries as UNCLAIMED=2'b00, SOFT=2'b01, HARD=2'b10; 2'b11 is reserved and is never written.

Function
REQ-004 SHALL have a two-state FSM, IDLE and SCAN, plus an 8-bit scan index idx.
REQ-005 In IDLE, if age_tick=1 and dplca_aging=1, the FSM SHALL go to SCAN with idx=0.
REQ-006 In each SCAN cycle without a claim write, entry[idx] SHALL age: HARD->SOFT, SOFT->UNCLAIMED, UNCLAIMED unchanged; idx then increments.
REQ-007 A claim write SHALL have priority over scan access. In a cycle where claim_valid=1, entry[claim_id]:=HARD and the scan stalls (idx holds, no aging that cycle).
REQ-008 When idx=255 is aged, the FSM SHALL return to IDLE and set dplca_new_age=1 on the next cycle. A full scan takes at least 256 cycles plus one per stall.
REQ-009 beacon_seen in IDLE SHALL produce a dplca_txop_table_upd pulse exactly 1 cycle later.
REQ-010 beacon_seen during SCAN SHALL set a pending flag. The pulse SHALL be issued the cycle after the scan completes, in the same cycle dplca_new_age first reads 1.
REQ-011 Multiple beacon_seen pulses while pending SHALL collapse into one pulse.
REQ-012 dplca_new_age SHALL clear on the cycle after a dplca_txop_table_upd pulse, so consumers see upd and new_age high together exactly once.
REQ-013 max_hard_claim SHALL update as follows:
- On a HARD write with claim_id>current value, it takes claim_id.
- During a scan it is recomputed as the max idx whose post-scan state is HARD, including claims written mid-scan.
- It is valid from the cycle dplca_new_age rises.
REQ-014 age_tick during SCAN SHALL be ignored and SHALL set age_overrun.
REQ-015 claim_valid with claim_id equal to the entry being scanned in that cycle SHALL leave that entry HARD; the write wins and aging of that entry is skipped.
REQ-016 dplca_aging=0 SHALL, on the next edge:
- clear all entries to UNCLAIMED;
- abort any scan to IDLE;
- clear dplca_new_age, the pending flag, and max_hard_claim.
While dplca_aging=0, claims SHALL still be written and age_tick SHALL be ignored.

Reset
REQ-017 On plca_reset=1 all of the following SHALL hold the next cycle: FSM=IDLE, idx=0, every entry UNCLAIMED, all outputs 0, pending and age_overrun cleared.
REQ-018 Reset mid-scan SHALL abort the scan with no upd or new_age pulse.

Structure
REQ-019 Entry encodings and FSM state codes SHALL live in the shared D-PLCA parameter include; the table width (256 x 2) SHALL be a constant there.
REQ-020 One sub-module, dplca_max_claim_tracker (running max plus scan recompute), is natural; all other logic SHALL be flat.

Verification
REQ-021 Claim then age: claim_id=5, then age_tick → entry5=SOFT; second tick → UNCLAIMED; each scan takes 256 cycles and dplca_new_age rises.
REQ-022 Stall: claim_valid on 10 consecutive cycles mid-scan → scan completes in 266 cycles; claimed entries read HARD.
REQ-023 Deferred update: beacon_seen at scan cycle 100 → no upd until the scan completes, then one upd pulse coincident with new_age=1; new_age clears the next cycle.
REQ-024 Max tracking: HARD claims at 3, 200, 7 → max_hard_claim=200; after two ages with only 7 reclaimed → 7.
REQ-025 Abort: plca_reset at scan cycle 50, and separately dplca_aging=0 at scan cycle 50 → table all zero, FSM IDLE, no upd or new_age; age_tick during scan sets age_overrun.
